spi_xfer_ctrl: RTL

Transfer sequencer for the SPI master datapath. Buffers outgoing bytes in a small FIFO and runs a multi-byte transfer of programmed length. It drives slave select with setup/hold spacing, gates `baudrate_gen` through `sclk_en_o`, and feeds `spi_transmitter` byte by byte over its valid/ready port. It sits between the APB register block and the transmitter/baud-rate pair.

---
 rtl/spi_xfer_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_ctrl
//  Purpose  : SPI master transfer sequencer. Buffers outgoing bytes in a
//             small FIFO and runs a multi-byte transfer of programmed length,
//             framing it with slave select (setup/hold spacing), gating the
//             baud-rate generator and feeding the transmitter byte by byte.
//  Ports    : clk_i, rst          - clock, asynchronous active-high reset
//             start_i, len_i      - transfer request and byte count
//             abort_i             - abort request (SPI_XFER_ABORT_EN only)
//             wdata_i, wvalid_i,
//             wready_o            - TX FIFO write port
//             busy_o, done_o,
//             aborted_o           - status (registered)
//             ss_n_o, sclk_en_o   - slave select / baud-rate gate (registered)
//             tx_data_o, tx_valid_o,
//             tx_ready_i          - byte handshake towards the transmitter
//             sample_i            - one pulse per transferred bit
//  Options  : `define SPI_XFER_ABORT_EN to enable abort_i / aborted_o.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic [7:0]       wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             ss_n_o,
  output logic             sclk_en_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  input  logic             sample_i
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int DLY_W  = $clog2(CS_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_d, aborted_d, w_flush;
  logic             ss_n_q, sclk_en_q, busy_q, done_q, aborted_q;

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             w_empty, w_full, w_push, w_pop, w_abort;

  assign w_empty    = (wptr_q == rptr_q);
  assign w_full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_push     = wvalid_i && !w_full;
  assign tx_valid_o = (state_q == ST_LOAD) && !w_empty;
  assign w_pop      = tx_valid_o && tx_ready_i;
  assign tx_data_o  = tx_valid_o ? mem_q[rptr_q[AW-1:0]] : 8'h00;
  assign wready_o   = !w_full;

`ifdef SPI_XFER_ABORT_EN
  assign w_abort = abort_i && (state_q != ST_IDLE);
`else
  logic w_unused_abort;
  assign w_unused_abort = abort_i;
  assign w_abort        = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    w_flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (len_i != '0)) begin
          rem_d   = len_i;
          dly_d   = DLY_W'(CS_SETUP);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (dly_q <= DLY_W'(1)) state_d = ST_LOAD;
        else                    dly_d   = dly_q - DLY_W'(1);
      end
      ST_LOAD: begin
        if (w_pop) begin
          bit_d   = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sample_i) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              // The cycle of the last sample counts as the first hold
              // cycle, so ss_n rises CS_HOLD cycles after it.
              if (CS_HOLD <= 1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                dly_d   = DLY_W'(CS_HOLD - 1);
                state_d = ST_HOLD;
              end
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (dly_q <= DLY_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_abort) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      w_flush   = 1'b1;
    end
  end

  // FIFO pointer update; a flush overrides any simultaneous push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + (AW+1)'(1);
      if (w_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      bit_q     <= '0;
      rem_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ss_n_q    <= 1'b1;
      sclk_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ss_n_q    <= (state_d == ST_IDLE);
      sclk_en_q <= (state_d == ST_SHIFT);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign ss_n_o    = ss_n_q;
  assign sclk_en_o = sclk_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;

endmodule
`default_nettype wire
